// File: rtl/slc3_datapath_gen.sv
// SLC-3 datapath with a parametrised width: register file, ALU, address adder,
// architectural registers, condition codes and branch enable around one gated bus.
module slc3_datapath_gen #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter int unsigned      LED_W    = 12
) (
    input  logic             Clk,
    input  logic             Reset_ah,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_IR,
    input  logic             LD_BEN,
    input  logic             LD_CC,
    input  logic             LD_REG,
    input  logic             LD_PC,
    input  logic             LD_LED,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             ADDR1MUX,
    input  logic             MIO_EN,
    input  logic [WIDTH-1:0] MDR_In,
    output logic             BEN,
    output logic [2:0]       CC,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC,
    output logic [LED_W-1:0] LED,
    output logic             bus_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [2:0]       cc_q, cc_d;
    logic             ben_q, ben_d;
    logic             bus_err_q, bus_err_d;
    logic [WIDTH-1:0] rf_q [8];

    logic [2:0]       sr1, sr2, dr;
    logic [WIDTH-1:0] sr1_val, sr2_val;
    logic [WIDTH-1:0] imm5, off6, off9, off11;
    logic [WIDTH-1:0] alu_b, alu_out;
    logic [WIDTH-1:0] addr1, addr2, adder_out;
    logic [3:0]       gates;
    logic             multi_gate;
    logic [WIDTH-1:0] bus;

    // IR fields keep their LC-3 positions regardless of WIDTH
    assign sr2 = ir_q[2:0];
    assign sr1 = SR1MUX ? ir_q[8:6] : ir_q[11:9];
    assign dr  = DRMUX ? 3'd7 : ir_q[11:9];

    assign imm5  = {{(WIDTH-5){ir_q[4]}},   ir_q[4:0]};
    assign off6  = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
    assign off9  = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
    assign off11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};

    assign sr1_val = rf_q[sr1];
    assign sr2_val = rf_q[sr2];
    assign alu_b   = SR2MUX ? imm5 : sr2_val;

    always_comb begin
        alu_out = sr1_val;
        case (ALUK)
            2'd0:    alu_out = sr1_val + alu_b;
            2'd1:    alu_out = sr1_val & alu_b;
            2'd2:    alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
    end

    assign addr1 = ADDR1MUX ? sr1_val : pc_q;

    always_comb begin
        addr2 = '0;
        case (ADDR2MUX)
            2'd0:    addr2 = '0;
            2'd1:    addr2 = off6;
            2'd2:    addr2 = off9;
            default: addr2 = off11;
        endcase
    end

    assign adder_out = addr1 + addr2;

    // Idle or contended gating leaves the bus at zero instead of floating
    assign gates      = {GateMARMUX, GatePC, GateALU, GateMDR};
    assign multi_gate = |(gates & (gates - 4'd1));

    always_comb begin
        bus = '0;
        case (gates)
            4'b1000: bus = adder_out;
            4'b0100: bus = pc_q;
            4'b0010: bus = alu_out;
            4'b0001: bus = mdr_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        ir_d      = ir_q;
        led_d     = led_q;
        cc_d      = cc_q;
        ben_d     = ben_q;
        bus_err_d = bus_err_q | multi_gate;
        if (LD_PC) begin
            case (PCMUX)
                2'd0:    pc_d = pc_q + WIDTH'(1);
                2'd1:    pc_d = bus;
                2'd2:    pc_d = adder_out;
                default: pc_d = pc_q;
            endcase
        end
        if (LD_MAR) mar_d = bus;
        if (LD_MDR) mdr_d = MIO_EN ? MDR_In : bus;
        if (LD_IR)  ir_d  = bus;
        if (LD_LED) led_d = ir_q[LED_W-1:0];
        if (LD_CC) begin
            cc_d = {bus[WIDTH-1], (bus == '0), (!bus[WIDTH-1] && (bus != '0))};
        end
        // Pre-edge IR and CC: a same-cycle LD_IR/LD_CC is seen on the next load
        if (LD_BEN) ben_d = |(ir_q[11:9] & cc_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            pc_q      <= PC_RESET;
            mar_q     <= '0;
            mdr_q     <= '0;
            ir_q      <= '0;
            led_q     <= '0;
            cc_q      <= 3'b010;
            ben_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            ir_q      <= ir_d;
            led_q     <= led_d;
            cc_q      <= cc_d;
            ben_q     <= ben_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (LD_REG) begin
            rf_q[dr] <= bus;
        end
    end

    assign PC      = pc_q;
    assign MAR     = mar_q;
    assign MDR     = mdr_q;
    assign IR      = ir_q;
    assign LED     = led_q;
    assign CC      = cc_q;
    assign BEN     = ben_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_slc3_datapath_gen.sv
// Bench for slc3_datapath_gen: a 16-bit and a 32-bit instance share the control
// inputs; a width-generic arithmetic model predicts every architectural output.
module tb_slc3_datapath_gen;

    logic        clk = 1'b0;
    logic        reset_ah;
    logic        ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0]  pcmux, addr2mux, aluk;
    logic        drmux, sr1mux, sr2mux, addr1mux, mio_en;
    logic [15:0] mdr_in16;
    logic [31:0] mdr_in32;

    logic        ben16, ben32, err16, err32;
    logic [2:0]  cc16, cc32;
    logic [15:0] mar16, mdr16, ir16, pc16;
    logic [31:0] mar32, mdr32, ir32, pc32;
    logic [11:0] led16;
    logic [19:0] led32;

    int n_checks = 0;
    int n_errs   = 0;
    logic [63:0] exp_q[$];

    // Reference model state, index 0 = 16-bit instance, 1 = 32-bit instance
    int unsigned     wd[2]   = '{16, 32};
    int unsigned     ledw[2] = '{12, 20};
    longint unsigned pcrst[2] = '{64'h0, 64'h3000};
    longint unsigned m_pc[2], m_mar[2], m_mdr[2], m_ir[2], m_led[2];
    longint unsigned m_cc[2], m_ben[2], m_err[2];
    longint unsigned m_r[2][8];

    always #5 clk = ~clk;

    slc3_datapath_gen #(.WIDTH(16), .PC_RESET(16'h0000), .LED_W(12)) dut16 (
        .Clk(clk), .Reset_ah(reset_ah),
        .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
        .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
        .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
        .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
        .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
        .MIO_EN(mio_en), .MDR_In(mdr_in16),
        .BEN(ben16), .CC(cc16), .MAR(mar16), .MDR(mdr16), .IR(ir16), .PC(pc16),
        .LED(led16), .bus_err(err16)
    );

    slc3_datapath_gen #(.WIDTH(32), .PC_RESET(32'h0000_3000), .LED_W(20)) dut32 (
        .Clk(clk), .Reset_ah(reset_ah),
        .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
        .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
        .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
        .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
        .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
        .MIO_EN(mio_en), .MDR_In(mdr_in32),
        .BEN(ben32), .CC(cc32), .MAR(mar32), .MDR(mdr32), .IR(ir32), .PC(pc32),
        .LED(led32), .bus_err(err32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned msk(int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned sx(longint unsigned x, int unsigned bits, int unsigned w);
        longint unsigned v = x & msk(bits);
        if (((v >> (bits - 1)) & 64'd1) != 0) v = v | (~64'd0 << bits);
        return v & msk(w);
    endfunction

    // One clock edge of the model, computed from the pre-edge state
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            longint unsigned m = msk(wd[k]);
            longint unsigned ir = m_ir[k];
            longint unsigned a, b, alu, adder, bus, sel_a2, mdr_src;
            longint unsigned n, z, p;
            int ng;
            int sr1 = sr1mux ? int'((ir >> 6) & 7) : int'((ir >> 9) & 7);
            int dr  = drmux ? 7 : int'((ir >> 9) & 7);
            a = m_r[k][sr1];
            b = sr2mux ? sx(ir, 5, wd[k]) : m_r[k][ir & 7];
            case (aluk)
                2'd0:    alu = (a + b) & m;
                2'd1:    alu = a & b;
                2'd2:    alu = (~a) & m;
                default: alu = a;
            endcase
            case (addr2mux)
                2'd0:    sel_a2 = 0;
                2'd1:    sel_a2 = sx(ir, 6, wd[k]);
                2'd2:    sel_a2 = sx(ir, 9, wd[k]);
                default: sel_a2 = sx(ir, 11, wd[k]);
            endcase
            adder = ((addr1mux ? a : m_pc[k]) + sel_a2) & m;
            ng = int'(gate_marmux) + int'(gate_pc) + int'(gate_alu) + int'(gate_mdr);
            bus = 0;
            if (ng == 1) begin
                if (gate_marmux)   bus = adder;
                else if (gate_pc)  bus = m_pc[k];
                else if (gate_alu) bus = alu;
                else               bus = m_mdr[k];
            end
            mdr_src = (k == 0) ? longint'(mdr_in16) : longint'(mdr_in32);
            if (reset_ah) begin
                m_pc[k] = pcrst[k]; m_mar[k] = 0; m_mdr[k] = 0; m_ir[k] = 0; m_led[k] = 0;
                m_cc[k] = 3'b010; m_ben[k] = 0; m_err[k] = 0;
                for (int i = 0; i < 8; i++) m_r[k][i] = 0;
            end else begin
                if (ld_ben) m_ben[k] = ((((ir >> 9) & 7) & m_cc[k]) != 0) ? 1 : 0;
                if (ld_led) m_led[k] = ir & msk(ledw[k]);
                if (ld_pc) begin
                    case (pcmux)
                        2'd0:    m_pc[k] = (m_pc[k] + 1) & m;
                        2'd1:    m_pc[k] = bus;
                        2'd2:    m_pc[k] = adder;
                        default: m_pc[k] = m_pc[k];
                    endcase
                end
                if (ld_mar) m_mar[k] = bus;
                if (ld_mdr) m_mdr[k] = mio_en ? mdr_src : bus;
                if (ld_ir)  m_ir[k]  = bus;
                if (ld_cc) begin
                    n = (bus >> (wd[k] - 1)) & 1;
                    z = (bus == 0) ? 1 : 0;
                    p = (n == 0 && z == 0) ? 1 : 0;
                    m_cc[k] = (n << 2) | (z << 1) | p;
                end
                if (ld_reg) m_r[k][dr] = bus;
                if (ng > 1) m_err[k] = 1;
            end
            exp_q.push_back(m_mar[k]); exp_q.push_back(m_mdr[k]);
            exp_q.push_back(m_ir[k]);  exp_q.push_back(m_pc[k]);
            exp_q.push_back(m_led[k]); exp_q.push_back(m_cc[k]);
            exp_q.push_back(m_ben[k]); exp_q.push_back(m_err[k]);
        end
    endtask

    task automatic scoreboard();
        chk("mar16", mar16, exp_q.pop_front()); chk("mdr16", mdr16, exp_q.pop_front());
        chk("ir16",  ir16,  exp_q.pop_front()); chk("pc16",  pc16,  exp_q.pop_front());
        chk("led16", led16, exp_q.pop_front()); chk("cc16",  cc16,  exp_q.pop_front());
        chk("ben16", ben16, exp_q.pop_front()); chk("err16", err16, exp_q.pop_front());
        chk("mar32", mar32, exp_q.pop_front()); chk("mdr32", mdr32, exp_q.pop_front());
        chk("ir32",  ir32,  exp_q.pop_front()); chk("pc32",  pc32,  exp_q.pop_front());
        chk("led32", led32, exp_q.pop_front()); chk("cc32",  cc32,  exp_q.pop_front());
        chk("ben32", ben32, exp_q.pop_front()); chk("err32", err32, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        scoreboard();
    endtask

    task automatic idle();
        reset_ah = 0;
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '0;
        {gate_pc, gate_mdr, gate_alu, gate_marmux} = '0;
        pcmux = 0; addr2mux = 0; aluk = 0;
        {drmux, sr1mux, sr2mux, addr1mux, mio_en} = '0;
    endtask

    task automatic load_mdr2(input logic [15:0] v16, input logic [31:0] v32);
        idle(); mio_en = 1; ld_mdr = 1; mdr_in16 = v16; mdr_in32 = v32; tick(); idle();
    endtask

    task automatic load_mdr(input logic [15:0] v);
        load_mdr2(v, {{16{v[15]}}, v});
    endtask

    task automatic load_ir(input logic [15:0] v);
        load_mdr(v); gate_mdr = 1; ld_ir = 1; tick(); idle();
    endtask

    task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
        load_ir({4'b0, r, 9'b0}); load_mdr(v); gate_mdr = 1; ld_reg = 1; tick(); idle();
    endtask

    task automatic set_pc(input logic [15:0] v);
        load_mdr(v); gate_mdr = 1; pcmux = 1; ld_pc = 1; tick(); idle();
    endtask

    task automatic read_reg(input logic [2:0] r);
        load_ir({7'b0, r, 6'b0}); sr1mux = 1; aluk = 3; gate_alu = 1; ld_mar = 1; tick(); idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(); mdr_in16 = 0; mdr_in32 = 0;
        // Reset beats every load and a live gate
        reset_ah = 1;
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '1;
        gate_pc = 1;
        tick();
        chk("rst_pc16", pc16, 16'h0000); chk("rst_pc32", pc32, 32'h3000);
        chk("rst_cc16", cc16, 3'b010);   chk("rst_ben16", ben16, 0);
        chk("rst_err16", err16, 0);      chk("rst_mar16", mar16, 0);
        chk("rst_ir16", ir16, 0);
        idle();

        // ADD R0,R1,R2 with positive and negative results
        set_reg(1, 16'd5); set_reg(2, 16'hFFFD); load_ir(16'h1042);
        sr1mux = 1; gate_alu = 1; ld_reg = 1; ld_cc = 1; tick(); idle();
        chk("add_cc16", cc16, 3'b001); chk("add_cc32", cc32, 3'b001);
        read_reg(0);
        chk("add_r0_16", mar16, 16'h0002); chk("add_r0_32", mar32, 32'h2);
        set_reg(2, 16'hFFFA); load_ir(16'h1042);
        sr1mux = 1; gate_alu = 1; ld_reg = 1; ld_cc = 1; tick(); idle();
        chk("addn_cc16", cc16, 3'b100);
        read_reg(0);
        chk("addn_r0_16", mar16, 16'hFFFF); chk("addn_r0_32", mar32, 32'hFFFF_FFFF);

        // Branch enable and PC-relative target, positive and negative offset
        load_ir(16'h0E05); set_pc(16'h3000);
        ld_ben = 1; tick(); idle();
        chk("br_ben16", ben16, 1);
        pcmux = 2; addr2mux = 2; ld_pc = 1; tick(); idle();
        chk("br_pc16", pc16, 16'h3005); chk("br_pc32", pc32, 32'h3005);
        load_ir(16'h01FE); set_pc(16'h3001);
        ld_ben = 1; tick(); idle();
        chk("brn_ben16", ben16, 0);
        pcmux = 2; addr2mux = 2; ld_pc = 1; tick(); idle();
        chk("brn_pc16", pc16, 16'h2FFF); chk("brn_pc32", pc32, 32'h2FFF);

        // Bus contention is sticky until reset
        gate_pc = 1; gate_mdr = 1; ld_mar = 1; tick(); idle();
        chk("cont_mar16", mar16, 0); chk("cont_err16", err16, 1); chk("cont_err32", err32, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("cont_hold16", err16, 1);
        end
        reset_ah = 1; tick(); idle();
        chk("cont_clr16", err16, 0);

        // PC increment wrap and explicit hold
        set_pc(16'hFFFF);
        pcmux = 0; ld_pc = 1; tick(); idle();
        chk("wrap_pc16", pc16, 0); chk("wrap_pc32", pc32, 0);
        set_pc(16'h1234);
        pcmux = 3; ld_pc = 1; tick(); idle();
        chk("hold_pc16", pc16, 16'h1234);

        // ADD R0,R0,#-1 from zero and a full-width memory load
        set_reg(0, 16'h0000); load_ir(16'h103F);
        sr1mux = 1; sr2mux = 1; gate_alu = 1; ld_reg = 1; ld_cc = 1; tick(); idle();
        chk("imm_cc32", cc32, 3'b100);
        read_reg(0);
        chk("imm_r0_32", mar32, 32'hFFFF_FFFF); chk("imm_r0_16", mar16, 16'hFFFF);
        load_mdr2(16'hBEEF, 32'hDEAD_BEEF);
        chk("mem_mdr32", mdr32, 32'hDEAD_BEEF); chk("mem_mdr16", mdr16, 16'hBEEF);

        // LED takes the low IR bits
        load_ir(16'h0ABC); ld_led = 1; tick(); idle();
        chk("led16", led16, 12'hABC); chk("led32", led32, 20'h00ABC);

        // Randomised traffic against the model
        for (int c = 0; c < 500; c++) begin
            int g = $urandom_range(0, 19);
            idle();
            if (g < 12) begin
                case (g % 4)
                    0: gate_pc = 1;
                    1: gate_mdr = 1;
                    2: gate_alu = 1;
                    default: gate_marmux = 1;
                endcase
            end else if (g >= 18) begin
                gate_alu = 1;
                if (g == 18) gate_pc = 1; else gate_marmux = 1;
            end
            reset_ah = ($urandom_range(0, 39) == 0);
            {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = 8'($urandom);
            pcmux = 2'($urandom); addr2mux = 2'($urandom); aluk = 2'($urandom);
            {drmux, sr1mux, sr2mux, addr1mux, mio_en} = 5'($urandom);
            mdr_in16 = 16'($urandom);
            mdr_in32 = $urandom;
            tick();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
